apb_master_module: RTL and testbench
====================================

Name: apb_master_module

Overview:
APB4 initiator that drives the matmul accelerator's APB slave port from a simple valid/ready command interface, for use by the bench driver and by the SoC control path. It turns each command into a SETUP phase and an ACCESS phase on APB, waits for pready, and returns one response per command carrying read data, slave error and timeout flags. It can optionally stall a command until the accelerator's busy output drops. A watchdog aborts transfers that stall too long.

Parameters:
DATA_WIDTH, 8, element width; the strobe granularity.
BUS_WIDTH, 16, APB data width.
ADDR_WIDTH, 32, APB address width.
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with pready low before abort; 0 disables the watchdog.
MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, strobe width.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
cmd_valid_i  in  1  command request.
cmd_ready_o  out  1  command accepted when valid and ready are both high.
cmd_write_i  in  1  1 = write, 0 = read.
cmd_addr_i  in  ADDR_WIDTH  target address.
cmd_wdata_i  in  BUS_WIDTH  write data.
cmd_strb_i  in  MAX_DIM  byte-lane strobes.
cmd_wait_busy_i  in  1  hold the command until busy_i is low.
busy_i  in  1  accelerator busy (matmul busy_o).
rsp_valid_o  out  1  one-cycle response pulse.
rsp_rdata_o  out  BUS_WIDTH  read data; 0 for writes and aborts.
rsp_err_o  out  1  pslverr sampled, or timeout.
rsp_timeout_o  out  1  watchdog abort.
psel_o, penable_o, pwrite_o  out  1  APB control.
paddr_o  out  ADDR_WIDTH  APB address.
pwdata_o  out  BUS_WIDTH  APB write data.
pstrb_o  out  MAX_DIM  APB strobes.
pready_i, pslverr_i  in  1  APB response.
prdata_i  in  BUS_WIDTH  APB read data.

Behaviour:
- Reset (asynchronous, active-low): every output is 0, the state is IDLE, and the watchdog counter is cleared.
- All outputs are registered.
- cmd_ready_o = (state == IDLE). The command fields are captured on acceptance.
- FSM states: IDLE, WAIT_BUSY, SETUP, ACCESS.
  - IDLE: on accept, go to WAIT_BUSY if cmd_wait_busy_i && busy_i, else go to SETUP.
  - WAIT_BUSY: hold until busy_i is sampled low, then go to SETUP. There is no timeout in this state.
  - SETUP: exactly one cycle with psel_o=1, penable_o=0; then go to ACCESS.
  - ACCESS: psel_o=1, penable_o=1.
    - If pready_i: go to IDLE. Capture rdata (reads only) and err=pslverr_i. Set rsp_valid_o=1 in the next cycle.
    - If the watchdog count reaches TIMEOUT_CYCLES with no pready: go to IDLE and drop psel_o/penable_o. Set rsp_valid_o=1 with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
- Watchdog counter:
  - Increments on each ACCESS cycle with pready_i low.
  - Clears on entry to SETUP.
  - Wide enough for TIMEOUT_CYCLES with no wrap.
- APB output rules:
  - paddr_o, pwrite_o, pwdata_o and pstrb_o are set when SETUP is entered and held stable through ACCESS.
  - They return to 0 in IDLE.
  - For reads, pstrb_o=0 and pwdata_o=0 regardless of cmd_strb_i.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS in N+2 → with pready high in N+2, rsp_valid_o is high in N+3. cmd_ready_o is also high in N+3, so a back-to-back command can be accepted then; throughput is one transfer per 3 cycles.
- Response lifetime:
  - rsp_rdata_o, rsp_err_o and rsp_timeout_o are valid only while rsp_valid_o is high.
  - They are cleared on the following cycle unless a new response is produced.
- Simultaneous events: in ACCESS, if pready_i is high in the same cycle the counter would hit the limit, pready wins (normal completion, no timeout).
- busy_i is ignored when cmd_wait_busy_i=0.
- Reset mid-transfer: the bus is released immediately (psel_o/penable_o=0) and no response is issued.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, WAIT_BUSY, SETUP, ACCESS);
  - MAX_DIM function;
  - command and response struct typedefs.
- The block is flat. The FSM and watchdog are small, so no sub-module.

Test Plan:
1. Write 0x0000_0010, data 0xABCD, strb 2'b11, pready high on the first ACCESS → SETUP at N+1 and ACCESS at N+2 with paddr_o=0x10, pwdata_o=0xABCD, pstrb_o=2'b11; rsp_valid_o at N+3 with err=0, rdata=0.
2. Read 0x0000_0020 (cmd_strb_i=2'b11), slave returns prdata=0x1234 after two wait cycles → pstrb_o=0; ACCESS lasts 3 cycles; rsp_rdata_o=0x1234, rsp_err_o=0.
3. Write with pslverr_i=1 at pready → rsp_err_o=1, rsp_timeout_o=0.
4. TIMEOUT_CYCLES=4, pready held low → psel_o drops after 4 ACCESS cycles; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; the next command is accepted the following cycle.
5. cmd_wait_busy_i=1 with busy_i high for 5 cycles → no psel_o during those cycles; SETUP occurs the cycle after busy_i is sampled low. The same command with cmd_wait_busy_i=0 proceeds immediately.
6. Assert rst_ni low during ACCESS → all outputs 0 immediately, no rsp_valid_o. After release, a new command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 initiator that drives the matmul
// accelerator's register port.
package apb_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        SETUP     = 2'd2,
        ACCESS    = 2'd3
    } apb_state_e;

    // Control bits of an incoming command.
    typedef struct packed {
        logic write;
        logic wait_busy;
    } cmd_ctrl_t;

    // Status flags returned with every response.
    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_flags_t;

    // Number of strobe lanes on the bus.
    function automatic int max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Counter width able to hold 0..limit without wrapping (at least 1 bit).
    function automatic int cnt_width(input int limit);
        if (limit < 2) begin
            return 1;
        end else begin
            return $clog2(limit + 1);
        end
    endfunction

endpackage

// File: rtl/apb_master_module.sv
// APB4 initiator: turns valid/ready commands into SETUP/ACCESS transfers,
// optionally waits for the accelerator to go idle first, and returns one
// registered response per command. A watchdog aborts stalled ACCESS phases.
module apb_master_module
    import apb_pkg::*;
#(
    parameter int  DATA_WIDTH     = 8,
    parameter int  BUS_WIDTH      = 16,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int MAX_DIM        = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // command interface
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    input  logic                  cmd_wait_busy_i,
    input  logic                  busy_i,
    // response interface
    output logic                  rsp_valid_o,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    // APB4 initiator port
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             WDOG_EN   = (TIMEOUT_CYCLES != 0);

    // FSM and watchdog
    apb_state_e          state_r;
    apb_state_e          state_s;
    logic [CNT_W-1:0]    wdog_r;
    logic [CNT_W-1:0]    wdog_s;
    logic [CNT_W-1:0]    wdog_inc_s;
    logic                timeout_hit_s;

    // command captured on acceptance (needed when leaving WAIT_BUSY)
    logic                  write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [BUS_WIDTH-1:0]  wdata_r;
    logic [MAX_DIM-1:0]    strb_r;

    cmd_ctrl_t             cmd_ctrl_s;
    logic                  accept_s;

    // source of the APB fields when SETUP is entered
    logic                  src_write_s;
    logic [ADDR_WIDTH-1:0] src_addr_s;
    logic [BUS_WIDTH-1:0]  src_wdata_s;
    logic [MAX_DIM-1:0]    src_strb_s;

    // next values of the registered outputs
    logic                  cmd_ready_s;
    logic                  psel_s;
    logic                  penable_s;
    logic                  pwrite_s;
    logic [ADDR_WIDTH-1:0] paddr_s;
    logic [BUS_WIDTH-1:0]  pwdata_s;
    logic [MAX_DIM-1:0]    pstrb_s;
    logic                  rsp_valid_s;
    logic [BUS_WIDTH-1:0]  rsp_rdata_s;
    rsp_flags_t            rsp_flags_s;
    rsp_flags_t            rsp_flags_r;

    assign cmd_ctrl_s    = '{write: cmd_write_i, wait_busy: cmd_wait_busy_i};
    assign accept_s      = cmd_valid_i & cmd_ready_o;
    assign wdog_inc_s    = wdog_r + CNT_ONE;
    assign timeout_hit_s = WDOG_EN & (wdog_inc_s == CNT_LIMIT);

    assign rsp_err_o     = rsp_flags_r.err;
    assign rsp_timeout_o = rsp_flags_r.timeout;

    // Select the command fields that feed SETUP: live inputs straight from
    // IDLE, the captured copy when coming out of WAIT_BUSY. Reads never
    // drive write data or strobes.
    always_comb begin
        src_write_s = 1'b0;
        src_addr_s  = '0;
        src_wdata_s = '0;
        src_strb_s  = '0;
        if (state_r == IDLE) begin
            src_write_s = cmd_ctrl_s.write;
            src_addr_s  = cmd_addr_i;
            src_wdata_s = cmd_wdata_i;
            src_strb_s  = cmd_strb_i;
        end else begin
            src_write_s = write_r;
            src_addr_s  = addr_r;
            src_wdata_s = wdata_r;
            src_strb_s  = strb_r;
        end
        if (!src_write_s) begin
            src_wdata_s = '0;
            src_strb_s  = '0;
        end else begin
            src_wdata_s = src_wdata_s;
            src_strb_s  = src_strb_s;
        end
    end

    // Next-state, watchdog and response generation.
    always_comb begin
        state_s     = state_r;
        wdog_s      = wdog_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = '0;
        rsp_flags_s = '{err: 1'b0, timeout: 1'b0};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (cmd_ctrl_s.wait_busy && busy_i) begin
                        state_s = WAIT_BUSY;
                    end else begin
                        state_s = SETUP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (!busy_i) begin
                    state_s = SETUP;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            SETUP: begin
                state_s = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a watchdog hit in the same cycle
                if (pready_i) begin
                    state_s             = IDLE;
                    rsp_valid_s         = 1'b1;
                    rsp_rdata_s         = write_r ? '0 : prdata_i;
                    rsp_flags_s.err     = pslverr_i;
                    rsp_flags_s.timeout = 1'b0;
                end else if (timeout_hit_s) begin
                    state_s             = IDLE;
                    wdog_s              = wdog_inc_s;
                    rsp_valid_s         = 1'b1;
                    rsp_rdata_s         = '0;
                    rsp_flags_s.err     = 1'b1;
                    rsp_flags_s.timeout = 1'b1;
                end else begin
                    state_s = ACCESS;
                    if (WDOG_EN) begin
                        wdog_s = wdog_inc_s;
                    end else begin
                        wdog_s = wdog_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (state_s == SETUP) begin
            wdog_s = '0;
        end else begin
            wdog_s = wdog_s;
        end
    end

    // Next values of the APB outputs and command ready.
    always_comb begin
        cmd_ready_s = 1'b0;
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        pwrite_s    = 1'b0;
        paddr_s     = '0;
        pwdata_s    = '0;
        pstrb_s     = '0;
        case (state_s)
            IDLE: begin
                cmd_ready_s = 1'b1;
            end
            WAIT_BUSY: begin
                cmd_ready_s = 1'b0;
            end
            SETUP: begin
                psel_s   = 1'b1;
                pwrite_s = src_write_s;
                paddr_s  = src_addr_s;
                pwdata_s = src_wdata_s;
                pstrb_s  = src_strb_s;
            end
            ACCESS: begin
                psel_s    = 1'b1;
                penable_s = 1'b1;
                pwrite_s  = pwrite_o;
                paddr_s   = paddr_o;
                pwdata_s  = pwdata_o;
                pstrb_s   = pstrb_o;
            end
            default: begin
                cmd_ready_s = 1'b0;
            end
        endcase
    end

    // State register and watchdog counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            wdog_r  <= '0;
        end else begin
            state_r <= state_s;
            wdog_r  <= wdog_s;
        end
    end

    // Capture the command on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            strb_r  <= '0;
        end else if (accept_s) begin
            write_r <= cmd_ctrl_s.write;
            addr_r  <= cmd_addr_i;
            wdata_r <= cmd_wdata_i;
            strb_r  <= cmd_strb_i;
        end else begin
            write_r <= write_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            strb_r  <= strb_r;
        end
    end

    // Registered APB and command-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready_o <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
        end else begin
            cmd_ready_o <= cmd_ready_s;
            psel_o      <= psel_s;
            penable_o   <= penable_s;
            pwrite_o    <= pwrite_s;
            paddr_o     <= paddr_s;
            pwdata_o    <= pwdata_s;
            pstrb_o     <= pstrb_s;
        end
    end

    // Registered response; fields clear the cycle after the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_flags_r <= '{err: 1'b0, timeout: 1'b0};
        end else begin
            rsp_valid_o <= rsp_valid_s;
            rsp_rdata_o <= rsp_rdata_s;
            rsp_flags_r <= rsp_flags_s;
        end
    end

endmodule

// File: tb/tb_apb_master_module.sv
// Bench for apb_master_module: table of commands with a scripted APB slave,
// per-phase bus checks, and a response scoreboard.
module tb_apb_master_module;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_wait_busy, busy;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr;
    logic [15:0] pwdata, prdata;
    logic [1:0]  pstrb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [1:0]  strb;
        logic        wait_busy;
        int          busy_cyc;
        int          waits;
        logic        timeout;
        logic        slverr;
        logic [15:0] prdata;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    apb_master_module #(
        .DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
        .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .cmd_wait_busy_i(cmd_wait_busy), .busy_i(busy),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop and compare every response pulse; fields must be clear otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: actual response with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_timeout", rsp_timeout, e.to);
                end
            end else begin
                chk("rsp_fields_clear", {rsp_rdata, rsp_err, rsp_timeout}, 64'h0);
            end
        end
    end

    // Issue one command and play the slave side; called and returns at a negedge.
    task automatic do_cmd(input vec_t v);
        int n;
        int acc;
        exp_t e;
        logic [15:0] ew;
        logic [1:0]  es;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before", cmd_ready, 1'b1);
        ew      = v.write ? v.wdata : 16'h0;
        es      = v.write ? v.strb  : 2'b00;
        e.rdata = (v.write || v.timeout) ? 16'h0 : v.prdata;
        e.err   = v.timeout | v.slverr;
        e.to    = v.timeout;
        cmd_valid     = 1'b1;
        cmd_write     = v.write;
        cmd_addr      = v.addr;
        cmd_wdata     = v.wdata;
        cmd_strb      = v.strb;
        cmd_wait_busy = v.wait_busy;
        busy          = (v.busy_cyc > 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 16'h0; cmd_strb = 2'b00; cmd_wait_busy = 1'b0;
        if (v.wait_busy) begin
            for (int i = 0; i < v.busy_cyc; i++) begin
                @(negedge clk);
                chk("wait_busy_no_psel", psel, 1'b0);
                if (i == v.busy_cyc - 1) busy = 1'b0;
            end
        end
        @(negedge clk);
        chk("setup_psel_penable", {psel, penable}, 2'b10);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.write);
        chk("setup_pwdata", pwdata, ew);
        chk("setup_pstrb", pstrb, es);
        acc = v.timeout ? TO : v.waits + 1;
        for (int i = 0; i < acc; i++) begin
            @(negedge clk);
            chk("access_psel_penable", {psel, penable}, 2'b11);
            chk("access_fields_stable", {paddr, pwdata, pstrb, pwrite}, {v.addr, ew, es, v.write});
            if (!v.timeout && i == acc - 1) begin
                pready  = 1'b1;
                pslverr = v.slverr;
                prdata  = v.prdata;
            end
            @(posedge clk);
            #1;
            pready = 1'b0; pslverr = 1'b0; prdata = 16'h0;
        end
        @(negedge clk);
        chk("rsp_valid_timing", rsp_valid, 1'b1);
        chk("bus_released", {psel, penable, pwrite, paddr, pwdata, pstrb}, 64'h0);
        chk("cmd_ready_after", cmd_ready, 1'b1);
        busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t r;
        //          wr    addr          wdata     strb   wb    bc wt to    err   prdata
        vecs[0] = '{1'b1, 32'h0000_0010, 16'hABCD, 2'b11, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 32'h0000_0020, 16'hFFFF, 2'b11, 1'b0, 0, 2, 1'b0, 1'b0, 16'h1234};
        vecs[2] = '{1'b1, 32'h0000_0030, 16'h5555, 2'b01, 1'b0, 0, 1, 1'b0, 1'b1, 16'h0000};
        vecs[3] = '{1'b1, 32'h0000_0040, 16'h1111, 2'b11, 1'b0, 0, 0, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 32'h0000_0044, 16'h0000, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0, 16'hBEEF};
        vecs[5] = '{1'b0, 32'h0000_0050, 16'h0000, 2'b11, 1'b0, 0, 3, 1'b0, 1'b0, 16'h0F0F};
        vecs[6] = '{1'b1, 32'h0000_0060, 16'h2468, 2'b11, 1'b1, 5, 0, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 32'h0000_0060, 16'h2468, 2'b11, 1'b0, 5, 0, 1'b0, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 32'hDEAD_0008, 16'h0000, 2'b01, 1'b0, 0, 0, 1'b0, 1'b1, 16'h7777};
        vecs[9] = '{1'b1, 32'h0000_0070, 16'h00FF, 2'b10, 1'b0, 0, 1, 1'b0, 1'b0, 16'h0000};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 16'h0;
        cmd_strb = 2'b00; cmd_wait_busy = 1'b0; busy = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, 64'h0);
        chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i]);
        end

        // Reset asserted in the middle of ACCESS: bus drops at once, no response.
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080; cmd_strb = 2'b11;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_strb = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, 64'h0);
        chk("midreset_rsp_ready", {rsp_valid, cmd_ready}, 2'b00);
        repeat (2) begin
            @(negedge clk);
            chk("midreset_no_rsp", rsp_valid, 1'b0);
        end
        rst_n = 1'b1;
        r = '{1'b0, 32'h0000_0090, 16'h0000, 2'b11, 1'b0, 0, 1, 1'b0, 1'b0, 16'hC0DE};
        do_cmd(r);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
